// File: rtl/fsm_ctl_pkg.sv
// Shared definitions for controllers that steer the 2-bit x/y protocol FSM:
// FSM state codes, arbiter state encoding and the "return to S0" drive helper.
package fsm_ctl_pkg;

  typedef logic [1:0] fsm_st_t;

  localparam fsm_st_t S0 = 2'b00;
  localparam fsm_st_t S1 = 2'b01;
  localparam fsm_st_t S2 = 2'b10;
  localparam fsm_st_t S3 = 2'b11;

  typedef enum logic [1:0] {
    IDLE  = 2'b00,
    GRANT = 2'b01,
    DRAIN = 2'b10
  } arb_st_e;

  // x value that takes the FSM from any state back to S0 in one clock (y held 0).
  function automatic logic drain_x(input fsm_st_t st);
    case (st)
      S1, S2, S3: drain_x = 1'b1;
      default:    drain_x = 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/rr_pick.sv
// Combinational round-robin picker: first asserted request scanning upward
// from ptr_i with wrap-around; the request at ptr_i itself has top priority.
module rr_pick #(
  parameter int NREQ = 2,
  parameter int PW   = $clog2(NREQ)
) (
  input  logic [NREQ-1:0] req_i,
  input  logic [PW-1:0]   ptr_i,
  output logic [NREQ-1:0] win_oh_o,
  output logic [PW-1:0]   win_idx_o,
  output logic            valid_o
);

  always_comb begin
    int j;
    j         = 0;
    win_oh_o  = '0;
    win_idx_o = '0;
    valid_o   = 1'b0;
    for (int i = 0; i < NREQ; i++) begin
      j = (int'(ptr_i) + i) % NREQ;
      if (!valid_o && req_i[j]) begin
        valid_o     = 1'b1;
        win_oh_o[j] = 1'b1;
        win_idx_o   = PW'(j);
      end
    end
  end

endmodule

// File: rtl/fsm_xy_arbiter.sv
// Round-robin sharing of one x/y protocol FSM between NREQ requesters; the FSM
// is walked back to S0 between tenures so every owner starts from a known state.
module fsm_xy_arbiter
  import fsm_ctl_pkg::*;
#(
  parameter int NREQ    = 2,
  parameter int TIMEOUT = 8
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic [NREQ-1:0] req,
  input  logic [NREQ-1:0] req_x,
  input  logic [NREQ-1:0] req_y,
  output logic [NREQ-1:0] gnt,
  output logic [NREQ-1:0] done,
  output logic            timeout_err,
  output logic            busy,
  output logic            fsm_x,
  output logic            fsm_y,
  input  logic            fsm_a,
  input  logic            fsm_b
);

  localparam int PW = $clog2(NREQ);
  localparam int CW = $clog2(TIMEOUT);

  // Handshake: a requester raises req and holds it for its whole tenure; gnt
  // (registered, one-hot) marks the tenure, dropping req ends it, and done
  // pulses once the FSM is back in S0 so the requester knows the slot is closed.
  arb_st_e         state_q;
  logic [NREQ-1:0] gnt_q;
  logic [NREQ-1:0] done_q;
  logic            tmo_q;
  logic [PW-1:0]   ptr_q;
  logic [PW-1:0]   owner_q;
  logic [CW-1:0]   cnt_q;

  fsm_st_t         st;
  logic [NREQ-1:0] win_oh;
  logic [PW-1:0]   win_idx;
  logic            win_valid;

  assign st = {fsm_a, fsm_b};

  rr_pick #(
    .NREQ (NREQ),
    .PW   (PW)
  ) u_pick (
    .req_i     (req),
    .ptr_i     (ptr_q),
    .win_oh_o  (win_oh),
    .win_idx_o (win_idx),
    .valid_o   (win_valid)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      gnt_q   <= '0;
      done_q  <= '0;
      tmo_q   <= 1'b0;
      ptr_q   <= '0;
      owner_q <= '0;
      cnt_q   <= '0;
    end else begin
      done_q <= '0;
      tmo_q  <= 1'b0;
      case (state_q)
        IDLE: begin
          // A non-S0 FSM (e.g. after an arbiter-only reset) is drained first.
          if (win_valid && st == S0) begin
            gnt_q   <= win_oh;
            owner_q <= win_idx;
            cnt_q   <= '0;
            state_q <= GRANT;
          end
        end
        GRANT: begin
          if (!req[owner_q]) begin
            gnt_q   <= '0;
            state_q <= DRAIN;
          end else if (cnt_q == CW'(TIMEOUT - 1)) begin
            gnt_q   <= '0;
            tmo_q   <= 1'b1;
            state_q <= DRAIN;
          end else begin
            cnt_q <= cnt_q + 1'b1;
          end
        end
        DRAIN: begin
          if (st == S0) begin
            done_q  <= {{(NREQ-1){1'b0}}, 1'b1} << owner_q;
            ptr_q   <= (owner_q == PW'(NREQ - 1)) ? '0 : owner_q + 1'b1;
            state_q <= IDLE;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign gnt         = gnt_q;
  assign done        = done_q;
  assign timeout_err = tmo_q;
  assign busy        = (state_q != IDLE);
  assign fsm_x       = (state_q == GRANT) ? req_x[owner_q] : drain_x(st);
  assign fsm_y       = (state_q == GRANT) ? req_y[owner_q] : 1'b0;

endmodule

// File: tb/tb_fsm_xy_arbiter.sv
// Bench for fsm_xy_arbiter: a small x/y FSM model closes the loop, a vector
// table covers tenures and round-robin order, hand sequences cover timeout and reset.
module tb_fsm_xy_arbiter;

  localparam int NREQ    = 2;
  localparam int TIMEOUT = 8;

  logic            clk = 1'b0;
  logic            rst_n;
  logic [NREQ-1:0] req, req_x, req_y;
  logic [NREQ-1:0] gnt, done;
  logic            timeout_err, busy, fsm_x, fsm_y;
  logic            fsm_a, fsm_b;

  logic [1:0]      st_m = 2'b00;
  logic            force_en;
  logic [1:0]      force_val;

  int n_chk  = 0;
  int n_fail = 0;

  typedef struct {
    logic [1:0] req, rx, ry;
    logic [1:0] gnt, done;
    logic       tmo, busy, x, y;
    logic [1:0] st;
  } vec_t;

  vec_t vecs[$];

  fsm_xy_arbiter #(.NREQ(NREQ), .TIMEOUT(TIMEOUT)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .req         (req),
    .req_x       (req_x),
    .req_y       (req_y),
    .gnt         (gnt),
    .done        (done),
    .timeout_err (timeout_err),
    .busy        (busy),
    .fsm_x       (fsm_x),
    .fsm_y       (fsm_y),
    .fsm_a       (fsm_a),
    .fsm_b       (fsm_b)
  );

  // clock / reset block
  always #5 clk = ~clk;

  // Protocol FSM model: y=1 jumps to S2/S3, x=1 toggles S0<->S1 and returns S2/S3 to S0.
  always_ff @(posedge clk) begin
    if (force_en)   st_m <= force_val;
    else if (fsm_y) st_m <= {1'b1, fsm_x};
    else if (fsm_x) st_m <= (st_m == 2'b00) ? 2'b01 : 2'b00;
  end
  assign fsm_a = st_m[1];
  assign fsm_b = st_m[0];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic vec_t mk(input logic [1:0] rq, input logic [1:0] rx, input logic [1:0] ry,
                              input logic [1:0] g, input logic [1:0] d, input logic t,
                              input logic b, input logic x, input logic y, input logic [1:0] s);
    vec_t v;
    v.req = rq; v.rx = rx; v.ry = ry; v.gnt = g; v.done = d;
    v.tmo = t; v.busy = b; v.x = x; v.y = y; v.st = s;
    return v;
  endfunction

  task automatic apply_vec(input int i);
    @(negedge clk);
    req   = vecs[i].req;
    req_x = vecs[i].rx;
    req_y = vecs[i].ry;
    #1;
    chk($sformatf("vec%0d.gnt", i),  32'(gnt),         32'(vecs[i].gnt));
    chk($sformatf("vec%0d.done", i), 32'(done),        32'(vecs[i].done));
    chk($sformatf("vec%0d.tmo", i),  32'(timeout_err), 32'(vecs[i].tmo));
    chk($sformatf("vec%0d.busy", i), 32'(busy),        32'(vecs[i].busy));
    chk($sformatf("vec%0d.x", i),    32'(fsm_x),       32'(vecs[i].x));
    chk($sformatf("vec%0d.y", i),    32'(fsm_y),       32'(vecs[i].y));
    chk($sformatf("vec%0d.st", i),   32'(st_m),        32'(vecs[i].st));
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    int tmo_seen;

    // Single tenure of requester 0 that toggles the FSM; non-owner y=1 must not leak.
    //                req    rx     ry     gnt    done  tmo busy x  y  st
    vecs.push_back(mk(2'b00, 2'b00, 2'b10, 2'b00, 2'b00, 0, 0, 0, 0, 2'b00));
    vecs.push_back(mk(2'b01, 2'b01, 2'b10, 2'b00, 2'b00, 0, 0, 0, 0, 2'b00));
    vecs.push_back(mk(2'b01, 2'b01, 2'b10, 2'b01, 2'b00, 0, 1, 1, 0, 2'b00));
    vecs.push_back(mk(2'b01, 2'b01, 2'b10, 2'b01, 2'b00, 0, 1, 1, 0, 2'b01));
    vecs.push_back(mk(2'b01, 2'b01, 2'b10, 2'b01, 2'b00, 0, 1, 1, 0, 2'b00));
    vecs.push_back(mk(2'b00, 2'b00, 2'b10, 2'b01, 2'b00, 0, 1, 0, 0, 2'b01));
    vecs.push_back(mk(2'b00, 2'b00, 2'b10, 2'b00, 2'b00, 0, 1, 1, 0, 2'b01));
    vecs.push_back(mk(2'b00, 2'b00, 2'b10, 2'b00, 2'b00, 0, 1, 0, 0, 2'b00));
    vecs.push_back(mk(2'b01, 2'b01, 2'b10, 2'b00, 2'b01, 0, 0, 0, 0, 2'b00));
    vecs.push_back(mk(2'b00, 2'b01, 2'b10, 2'b01, 2'b00, 0, 1, 1, 0, 2'b00));
    vecs.push_back(mk(2'b00, 2'b01, 2'b10, 2'b00, 2'b00, 0, 1, 1, 0, 2'b01));
    vecs.push_back(mk(2'b00, 2'b01, 2'b10, 2'b00, 2'b00, 0, 1, 0, 0, 2'b00));
    vecs.push_back(mk(2'b00, 2'b00, 2'b00, 2'b00, 2'b01, 0, 0, 0, 0, 2'b00));
    // Both requesting: grants alternate, each done precedes the next grant.
    vecs.push_back(mk(2'b11, 2'b00, 2'b00, 2'b00, 2'b00, 0, 0, 0, 0, 2'b00));
    vecs.push_back(mk(2'b11, 2'b00, 2'b00, 2'b10, 2'b00, 0, 1, 0, 0, 2'b00));
    vecs.push_back(mk(2'b11, 2'b00, 2'b00, 2'b10, 2'b00, 0, 1, 0, 0, 2'b00));
    vecs.push_back(mk(2'b01, 2'b00, 2'b00, 2'b10, 2'b00, 0, 1, 0, 0, 2'b00));
    vecs.push_back(mk(2'b01, 2'b00, 2'b00, 2'b00, 2'b00, 0, 1, 0, 0, 2'b00));
    vecs.push_back(mk(2'b11, 2'b00, 2'b00, 2'b00, 2'b10, 0, 0, 0, 0, 2'b00));
    vecs.push_back(mk(2'b11, 2'b00, 2'b00, 2'b01, 2'b00, 0, 1, 0, 0, 2'b00));
    vecs.push_back(mk(2'b01, 2'b00, 2'b00, 2'b01, 2'b00, 0, 1, 0, 0, 2'b00));
    vecs.push_back(mk(2'b10, 2'b00, 2'b00, 2'b01, 2'b00, 0, 1, 0, 0, 2'b00));
    vecs.push_back(mk(2'b10, 2'b00, 2'b00, 2'b00, 2'b00, 0, 1, 0, 0, 2'b00));
    vecs.push_back(mk(2'b11, 2'b00, 2'b00, 2'b00, 2'b01, 0, 0, 0, 0, 2'b00));
    vecs.push_back(mk(2'b11, 2'b00, 2'b00, 2'b10, 2'b00, 0, 1, 0, 0, 2'b00));
    vecs.push_back(mk(2'b00, 2'b00, 2'b00, 2'b10, 2'b00, 0, 1, 0, 0, 2'b00));
    vecs.push_back(mk(2'b00, 2'b00, 2'b00, 2'b00, 2'b00, 0, 1, 0, 0, 2'b00));
    vecs.push_back(mk(2'b00, 2'b00, 2'b00, 2'b00, 2'b10, 0, 0, 0, 0, 2'b00));

    // Reset with the FSM parked in S3 and nobody requesting.
    rst_n = 1'b0; req = '0; req_x = '0; req_y = '0;
    force_en = 1'b1; force_val = 2'b11;
    @(negedge clk);
    force_en = 1'b0;
    #1;
    chk("rst.gnt",  32'(gnt),         32'h0);
    chk("rst.done", 32'(done),        32'h0);
    chk("rst.tmo",  32'(timeout_err), 32'h0);
    chk("rst.busy", 32'(busy),        32'h0);
    chk("rst.x",    32'(fsm_x),       32'h1);
    rst_n = 1'b1;
    #1;
    chk("rel.x",    32'(fsm_x), 32'h1);
    chk("rel.st",   32'(st_m),  32'h3);
    chk("rel.busy", 32'(busy),  32'h0);
    @(negedge clk); #1;
    chk("drained.st",   32'(st_m),  32'h0);
    chk("drained.x",    32'(fsm_x), 32'h0);
    chk("drained.gnt",  32'(gnt),   32'h0);
    chk("drained.busy", 32'(busy),  32'h0);

    for (int i = 0; i < vecs.size(); i++) apply_vec(i);

    // Timeout: owner 0 holds req; expect exactly TIMEOUT grant cycles.
    @(negedge clk); req = 2'b01; req_x = '0; req_y = '0; #1;
    chk("to.idle_gnt", 32'(gnt), 32'h0);
    @(negedge clk); #1;
    n = 0; tmo_seen = 0;
    while (gnt == 2'b01 && n < 30) begin
      n++;
      if (timeout_err) tmo_seen++;
      @(negedge clk); #1;
    end
    chk("to.gnt_cycles",  32'(n),           32'(TIMEOUT));
    chk("to.early_tmo",   32'(tmo_seen),    32'h0);
    chk("to.tmo_pulse",   32'(timeout_err), 32'h1);
    chk("to.drain_busy",  32'(busy),        32'h1);
    chk("to.drain_gnt",   32'(gnt),         32'h0);
    @(negedge clk); req = 2'b00; #1;
    chk("to.done",        32'(done),        32'h1);
    chk("to.tmo_cleared", 32'(timeout_err), 32'h0);
    chk("to.idle_busy",   32'(busy),        32'h0);

    // Release on the very cycle the counter reaches TIMEOUT-1: no timeout_err.
    @(negedge clk); req = 2'b01; #1;
    for (int i = 0; i < TIMEOUT; i++) begin
      @(negedge clk);
      if (i == TIMEOUT - 1) req = 2'b00;
      #1;
      chk($sformatf("rel_edge.gnt%0d", i), 32'(gnt), 32'h1);
    end
    @(negedge clk); #1;
    chk("rel_edge.gnt_off", 32'(gnt),         32'h0);
    chk("rel_edge.no_tmo",  32'(timeout_err), 32'h0);
    chk("rel_edge.busy",    32'(busy),        32'h1);
    @(negedge clk); #1;
    chk("rel_edge.done",    32'(done),        32'h1);
    chk("rel_edge.no_tmo2", 32'(timeout_err), 32'h0);

    // Reset pulse mid-GRANT while the FSM sits in S1.
    @(negedge clk); req = 2'b01; req_x = 2'b01; #1;
    @(negedge clk); #1;
    chk("mid.gnt", 32'(gnt),   32'h1);
    chk("mid.x",   32'(fsm_x), 32'h1);
    @(negedge clk); #1;
    chk("mid.st1", 32'(st_m), 32'h1);
    chk("mid.gnt2", 32'(gnt), 32'h1);
    #1 rst_n = 1'b0;
    #1;
    chk("mid_rst.gnt",  32'(gnt),         32'h0);
    chk("mid_rst.busy", 32'(busy),        32'h0);
    chk("mid_rst.done", 32'(done),        32'h0);
    chk("mid_rst.tmo",  32'(timeout_err), 32'h0);
    chk("mid_rst.x",    32'(fsm_x),       32'h1);
    rst_n = 1'b1;
    #1;
    chk("mid_rel.gnt", 32'(gnt),   32'h0);
    chk("mid_rel.x",   32'(fsm_x), 32'h1);
    @(negedge clk); #1;
    chk("mid_rel.st0",  32'(st_m), 32'h0);
    chk("mid_rel.gnt2", 32'(gnt),  32'h0);
    chk("mid_rel.done", 32'(done), 32'h0);
    chk("mid_rel.tmo",  32'(timeout_err), 32'h0);
    @(negedge clk); #1;
    chk("mid_rel.regrant", 32'(gnt), 32'h1);
    @(negedge clk); req = 2'b00; req_x = 2'b00; #1;
    repeat (4) @(negedge clk);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
